// File: rtl/apb_pkg.sv
// Shared definitions for the APB CSR requester: FSM state encoding,
// CSR slave register map and default bus widths.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } apb_state_e;

   localparam int unsigned REG_CTRL   = 0;
   localparam int unsigned REG_0      = 1;
   localparam int unsigned REG_1      = 2;
   localparam int unsigned REG_RES    = 3;
   localparam int unsigned REG_STATUS = 4;
   localparam int unsigned REG_NUMBER = 5;

   localparam int unsigned ADDR_WIDTH_DEFAULT   = $clog2(REG_NUMBER);
   localparam int unsigned BUS_SIZE_DEFAULT     = 32;
   localparam int unsigned TIMEOUT_DEFAULT      = 16;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase wait counter; expire fires on the LIMIT-th consecutive
// cycle without ready. Only instantiated with APB_MASTER_TIMEOUT_EN.
module apb_timeout_counter #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic expire
);

   localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // cnt holds the number of earlier stalled cycles, so the limit cycle is LIMIT-1
   assign expire = inc && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_csr_master.sv
// APB requester: one host command at a time, SETUP/ACCESS sequencing and a
// held response. Optional ACCESS timeout under `APB_MASTER_TIMEOUT_EN.
module apb_csr_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEFAULT,
   parameter int unsigned APB_BUS_SIZE   = BUS_SIZE_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [APB_BUS_SIZE-1:0] cmd_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [APB_BUS_SIZE-1:0] rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   output logic                    sel,
   output logic                    en,
   output logic                    write,
   output logic [ADDR_WIDTH-1:0]   addr,
   output logic [APB_BUS_SIZE-1:0] wdata,
   input  logic                    ready,
   input  logic                    slv_err,
   input  logic [APB_BUS_SIZE-1:0] rdata
);

   apb_state_e state;

`ifdef APB_MASTER_TIMEOUT_EN
   logic to_expire;

   apb_timeout_counter #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (state == ST_SETUP),
      .inc   ((state == ST_ACCESS) && !ready),
      .expire(to_expire)
   );
`else
   assign rsp_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         rsp_timeout <= 1'b0;
`endif
         sel       <= 1'b0;
         en        <= 1'b0;
         write     <= 1'b0;
         addr      <= '0;
         wdata     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  write     <= cmd_write;
                  addr      <= cmd_addr;
                  wdata     <= cmd_wdata;
                  sel       <= 1'b1;
                  en        <= 1'b0;
                  state     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               en    <= 1'b1;
               state <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (ready) begin
                  rsp_rdata <= write ? '0 : rdata;
                  rsp_err   <= slv_err;
`ifdef APB_MASTER_TIMEOUT_EN
                  rsp_timeout <= 1'b0;
`endif
                  rsp_valid <= 1'b1;
                  sel       <= 1'b0;
                  en        <= 1'b0;
                  state     <= ST_RESP;
               end
`ifdef APB_MASTER_TIMEOUT_EN
               else if (to_expire) begin
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  sel         <= 1'b0;
                  en          <= 1'b0;
                  state       <= ST_RESP;
               end
`endif
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_csr_master.sv
// Self-checking bench for apb_csr_master: directed vector table, reset and
// timeout sequences, then randomized transfers against a transaction model.
module tb_apb_csr_master;

   localparam int unsigned AW = 3;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;
   logic          sel, en, write;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          ready = 1'b0;
   logic          slv_err = 1'b0;
   logic [DW-1:0] rdata = '0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   apb_csr_master #(
      .ADDR_WIDTH    (AW),
      .APB_BUS_SIZE  (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .rsp_timeout(rsp_timeout),
      .sel        (sel),
      .en         (en),
      .write      (write),
      .addr       (addr),
      .wdata      (wdata),
      .ready      (ready),
      .slv_err    (slv_err),
      .rdata      (rdata)
   );

   typedef struct {
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      int            waits;
      logic          err;
      logic [DW-1:0] rd;
      int            hold;
      logic [DW-1:0] e_rdata;
      logic          e_err;
      logic          e_to;
      int            e_lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Transaction-level expectation: a slave that stalls `waits` cycles.
   task automatic model(input logic w, input logic err, input logic [DW-1:0] rd, input int waits,
                        output logic [DW-1:0] e_rdata, output logic e_err, output logic e_to,
                        output int e_lat);
      e_rdata = w ? '0 : rd;
      e_err   = err;
      e_to    = 1'b0;
      e_lat   = 3 + waits;
`ifdef APB_MASTER_TIMEOUT_EN
      if (waits >= int'(TO)) begin
         e_rdata = '0;
         e_err   = 1'b1;
         e_to    = 1'b1;
         e_lat   = 2 + int'(TO);
      end
`endif
   endtask

   // Issues one command, plays the slave, consumes the response after `hold` stalled cycles.
   task automatic run_xfer(input string tag, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input int waits, input logic err,
                           input logic [DW-1:0] rd, input int hold,
                           input logic [DW-1:0] e_rdata, input logic e_err, input logic e_to,
                           input int e_lat);
      int            guard;
      int            acc;
      int            lat;
      logic          bus_ok;
      logic          hold_ok;
      logic [DW-1:0] snap_rdata;
      logic          snap_err;
      logic          snap_to;
      guard = 0;
      while (!cmd_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      rsp_ready = (hold == 0);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = wd;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = $urandom;
      lat = 1;
      acc = 0;
      bus_ok = 1'b1;
      check({tag, "_setup"}, {62'd0, sel, en}, 64'b10);
      while (!rsp_valid && lat < 64) begin
         if (addr !== a || write !== w || wdata !== wd || sel !== 1'b1) bus_ok = 1'b0;
         if (sel && en) begin
            acc++;
            ready = (acc > waits);
         end else begin
            ready = 1'b0;
         end
         slv_err = ready ? err : 1'($urandom);
         rdata   = ready ? rd : $urandom;
         @(negedge clk);
         lat++;
      end
      ready = 1'b0;
      slv_err = 1'($urandom);
      rdata = $urandom;
      check({tag, "_bus_stable"}, 64'(bus_ok), 64'd1);
      check({tag, "_latency"}, 64'(lat), 64'(e_lat));
      check({tag, "_resp_bus_idle"}, {62'd0, sel, en}, 64'd0);
      check({tag, "_rdata"}, 64'(rsp_rdata), 64'(e_rdata));
      check({tag, "_err"}, 64'(rsp_err), 64'(e_err));
      check({tag, "_timeout"}, 64'(rsp_timeout), 64'(e_to));
      snap_rdata = rsp_rdata;
      snap_err   = rsp_err;
      snap_to    = rsp_timeout;
      hold_ok    = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_rdata !== snap_rdata ||
             rsp_err !== snap_err || rsp_timeout !== snap_to) hold_ok = 1'b0;
      end
      if (hold > 0) check({tag, "_resp_hold"}, 64'(hold_ok), 64'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_resp_done"}, {62'd0, rsp_valid, cmd_ready}, 64'b01);
   endtask

   vec_t vecs[6];

   initial begin
      logic [DW-1:0] m_rdata;
      logic          m_err;
      logic          m_to;
      int            m_lat;

      vecs[0] = '{1'b1, 3'd0, 32'h2,        0, 1'b0, 32'hA5A5A5A5, 0, 32'h0,        1'b0, 1'b0, 3};
      vecs[1] = '{1'b0, 3'd3, 32'h0,        1, 1'b0, 32'h0123456,  0, 32'h0123456,  1'b0, 1'b0, 4};
      vecs[2] = '{1'b0, 3'd0, 32'h0,        0, 1'b1, 32'h55,       5, 32'h55,       1'b1, 1'b0, 3};
      vecs[3] = '{1'b1, 3'd7, 32'h1234,     0, 1'b1, 32'hFFFF0000, 0, 32'h0,        1'b1, 1'b0, 3};
      vecs[4] = '{1'b0, 3'd4, 32'h0,        2, 1'b0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1'b0, 1'b0, 5};
      vecs[5] = '{1'b1, 3'd1, 32'hFFFFFFFF, 2, 1'b0, 32'h77,       2, 32'h0,        1'b0, 1'b0, 5};

      repeat (3) @(negedge clk);
      check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
      check("reset_outputs", {rsp_valid, rsp_err, rsp_timeout, sel, en, write, rsp_rdata[0 +: 16]},
            64'd0);
      check("reset_bus", {addr, wdata}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);

      for (int i = 0; i < 6; i++) begin
         run_xfer($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].waits,
                  vecs[i].err, vecs[i].rd, vecs[i].hold, vecs[i].e_rdata, vecs[i].e_err,
                  vecs[i].e_to, vecs[i].e_lat);
      end

      // reset while in ACCESS discards the transfer
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 3'd2;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_in_access", {62'd0, sel, en}, 64'b11);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_cleared", {61'd0, sel, en, rsp_valid}, 64'd0);
      check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd0);
      rst_n = 1'b1;
      ready = 1'b1;
      rdata = 32'hBAD0BAD0;
      @(negedge clk);
      check("rst_release_cmd_ready", 64'(cmd_ready), 64'd1);
      begin
         logic stale;
         stale = 1'b0;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid || sel || en) stale = 1'b1;
         end
         check("rst_no_stale_rsp", 64'(stale), 64'd0);
      end
      ready = 1'b0;

`ifdef APB_MASTER_TIMEOUT_EN
      run_xfer("to_never_ready", 1'b0, 3'd1, 32'h0, 100, 1'b0, 32'h1111, 0,
               32'h0, 1'b1, 1'b1, 6);
      run_xfer("to_ready_at_limit", 1'b0, 3'd1, 32'h0, 3, 1'b0, 32'h2222, 0,
               32'h2222, 1'b0, 1'b0, 6);
`endif

      for (int i = 0; i < 40; i++) begin
         logic          w;
         logic [AW-1:0] a;
         logic [DW-1:0] wd;
         logic [DW-1:0] rd;
         logic          err;
         int            waits;
         int            hold;
         w     = 1'($urandom);
         a     = AW'($urandom);
         wd    = $urandom;
         rd    = $urandom;
         err   = ($urandom_range(0, 3) == 0);
         waits = int'($urandom_range(0, 5));
         if (!w && (a == 3'd3 || a == 3'd4) && waits == 0) waits = 1;
         hold  = int'($urandom_range(0, 3));
         model(w, err, rd, waits, m_rdata, m_err, m_to, m_lat);
         run_xfer($sformatf("rnd%0d", i), w, a, wd, waits, err, rd, hold,
                  m_rdata, m_err, m_to, m_lat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
